// File: rtl/pipe_ctrl_if.sv
// Stall/flush bus between the pipeline control unit and the stage registers.
// The optional PIPE_PERF_EN counters are plain ports on pipe_ctrl, not part of this bus.
interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        wdt_timeout;
  logic [1:0]  state_o;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, wdt_timeout, state_o
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, wdt_timeout, state_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall arbitration, exception flush/redirect, post-flush FSM, stall watchdog.
// Optional macro PIPE_PERF_EN adds stall-cycle and flush-count performance counters.
module pipe_ctrl #(
  parameter int WDT_LIMIT = 255,
  parameter int CNT_W     = 32
) (
  input  logic           clk,
  input  logic           rst,
  pipe_ctrl_if.slave     bus
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o
`endif
);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_e;

  localparam logic [15:0] LIM = WDT_LIMIT[15:0];

  state_e      state_q, state_d;
  logic [15:0] wdt_cnt_q, wdt_cnt_d;
  logic        wdt_to_q, wdt_to_d;
  logic        exc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;

  always_comb begin
    state_d   = state_q;
    stall     = '0;
    flush     = 1'b0;
    new_pc    = '0;
    exc       = 1'b0;
    wdt_cnt_d = '0;
    wdt_to_d  = wdt_to_q;

    // The cycle after a flush carries only bubbles: requests and exceptions are ignored.
    if (!rst && state_q != FLUSH) begin
      exc = |bus.excepttype_i;
      if (exc) begin
        flush = 1'b1;
        case (bus.excepttype_i)
          32'h0000_0001: new_pc = 32'h0000_0020;
          32'h0000_000e: new_pc = bus.cp0_epc_i;
          default:       new_pc = 32'h0000_0040;
        endcase
      end else if (bus.stallreq_mem) stall = 6'b011111;
      else if (bus.stallreq_ex)       stall = 6'b001111;
      else if (bus.stallreq_id)       stall = 6'b000111;
      else if (bus.stallreq_if)       stall = 6'b000011;
    end

    case (state_q)
      RUN, STALL: begin
        if (exc)         state_d = FLUSH;
        else if (|stall) state_d = STALL;
        else             state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (|stall && !flush)
      wdt_cnt_d = (wdt_cnt_q == LIM) ? LIM : wdt_cnt_q + 16'd1;
    if (wdt_cnt_d == LIM)
      wdt_to_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wdt_cnt_q <= '0;
      wdt_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wdt_cnt_q <= wdt_cnt_d;
      wdt_to_q  <= wdt_to_d;
    end
  end

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cyc_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_q + CNT_W'(|stall);
      flush_cnt_q <= flush_cnt_q + CNT_W'(flush);
    end
  end

  assign stall_cycles_o = stall_cyc_q;
  assign flush_count_o  = flush_cnt_q;
`endif

  assign bus.stall       = stall;
  assign bus.flush       = flush;
  assign bus.new_pc      = new_pc;
  assign bus.wdt_timeout = wdt_to_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: history-based reference model checked every cycle plus directed literal checks.
module tb_pipe_ctrl;
  localparam int LIMIT = 4;
  localparam int CW    = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  pipe_ctrl_if u_if ();

`ifdef PIPE_PERF_EN
  logic [CW-1:0] stall_cycles, flush_count;
  pipe_ctrl #(.WDT_LIMIT(LIMIT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(u_if),
    .stall_cycles_o(stall_cycles), .flush_count_o(flush_count));
`else
  pipe_ctrl #(.WDT_LIMIT(LIMIT), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(u_if));
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: expected outputs from the previous cycle's observable history.
  bit valid = 0;
  bit h_flush, h_stall, wto;
  int wcnt;
  int p_stall, p_flush;

  always @(negedge clk) begin : model
    int lvl;
    bit e_flush;
    logic [5:0]  e_stall;
    logic [31:0] e_pc;
    logic [1:0]  e_state;
    if (rst) begin
      chk("rst_stall", {26'd0, u_if.stall}, 32'd0);
      chk("rst_flush", {31'd0, u_if.flush}, 32'd0);
      chk("rst_new_pc", u_if.new_pc, 32'd0);
      h_flush = 0; h_stall = 0; wto = 0; wcnt = 0; p_stall = 0; p_flush = 0;
      valid = 1;
    end else if (valid) begin
      lvl = u_if.stallreq_mem ? 4 : u_if.stallreq_ex ? 3 : u_if.stallreq_id ? 2 :
            u_if.stallreq_if ? 1 : 0;
      e_flush = !h_flush && (u_if.excepttype_i != 0);
      e_stall = (h_flush || e_flush || lvl == 0) ? 6'd0 : 6'((1 << (lvl + 1)) - 1);
      if (!e_flush)                          e_pc = 32'd0;
      else if (u_if.excepttype_i == 32'h1)   e_pc = 32'h20;
      else if (u_if.excepttype_i == 32'he)   e_pc = u_if.cp0_epc_i;
      else                                   e_pc = 32'h40;
      e_state = h_flush ? 2'd2 : h_stall ? 2'd1 : 2'd0;
      chk("m_stall", {26'd0, u_if.stall}, {26'd0, e_stall});
      chk("m_flush", {31'd0, u_if.flush}, {31'd0, e_flush});
      chk("m_new_pc", u_if.new_pc, e_pc);
      chk("m_state", {30'd0, u_if.state_o}, {30'd0, e_state});
      chk("m_wdt", {31'd0, u_if.wdt_timeout}, {31'd0, wto});
`ifdef PIPE_PERF_EN
      chk("m_stall_cycles", stall_cycles, p_stall);
      chk("m_flush_count", flush_count, p_flush);
`endif
      if (e_stall != 0) begin
        wcnt = (wcnt < LIMIT) ? wcnt + 1 : LIMIT;
        p_stall++;
      end else wcnt = 0;
      if (wcnt == LIMIT) wto = 1;
      if (e_flush) p_flush++;
      h_flush = e_flush;
      h_stall = (e_stall != 0);
    end
  end

  task automatic nxt(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  logic [31:0] exc_vec [5] = '{32'h8, 32'ha, 32'hd, 32'h5, 32'hffffffff};

  initial begin
    rst = 1;
    u_if.stallreq_if = 0; u_if.stallreq_id = 0; u_if.stallreq_ex = 0; u_if.stallreq_mem = 0;
    u_if.excepttype_i = 0; u_if.cp0_epc_i = 0;
    nxt(); smp();
    chk("reset_stall", {26'd0, u_if.stall}, 32'd0);
    nxt(); rst = 0; smp();
    chk("idle_state", {30'd0, u_if.state_o}, 32'd0);
    chk("idle_flush", {31'd0, u_if.flush}, 32'd0);
    chk("idle_new_pc", u_if.new_pc, 32'd0);
    chk("idle_wdt", {31'd0, u_if.wdt_timeout}, 32'd0);

    // ID + EX together: EX wins
    nxt(); u_if.stallreq_id = 1; u_if.stallreq_ex = 1;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("prio_stall", {26'd0, u_if.stall}, 32'h0f);
      if (i > 0) chk("prio_state", {30'd0, u_if.state_o}, 32'd1);
      nxt();
    end
    u_if.stallreq_id = 0; u_if.stallreq_ex = 0; smp();
    chk("drop_stall", {26'd0, u_if.stall}, 32'd0);
    nxt(); smp();
    chk("drop_state", {30'd0, u_if.state_o}, 32'd0);
    chk("short_stall_wdt", {31'd0, u_if.wdt_timeout}, 32'd0);

    // exception beats MEM stall, then flush cycle ignores MEM
    nxt(); u_if.stallreq_mem = 1; u_if.excepttype_i = 32'hc; smp();
    chk("exc_flush", {31'd0, u_if.flush}, 32'd1);
    chk("exc_new_pc", u_if.new_pc, 32'h40);
    chk("exc_stall", {26'd0, u_if.stall}, 32'd0);
    nxt(); u_if.excepttype_i = 0; smp();
    chk("fl_state", {30'd0, u_if.state_o}, 32'd2);
    chk("fl_flush", {31'd0, u_if.flush}, 32'd0);
    chk("fl_stall", {26'd0, u_if.stall}, 32'd0);
    nxt(); smp();
    chk("post_fl_stall", {26'd0, u_if.stall}, 32'h1f);
    nxt(); u_if.stallreq_mem = 0;

    // eret, exception held into the flush cycle, interrupt, generic codes
    nxt(); u_if.excepttype_i = 32'he; u_if.cp0_epc_i = 32'hbfc00100; smp();
    chk("eret_flush", {31'd0, u_if.flush}, 32'd1);
    chk("eret_new_pc", u_if.new_pc, 32'hbfc00100);
    nxt(); smp();
    chk("held_exc_flush", {31'd0, u_if.flush}, 32'd0);
    chk("held_exc_new_pc", u_if.new_pc, 32'd0);
    nxt(); u_if.excepttype_i = 32'h1; smp();
    chk("int_new_pc", u_if.new_pc, 32'h20);
    nxt(); u_if.excepttype_i = 0;
    foreach (exc_vec[k]) begin
      nxt(); u_if.excepttype_i = exc_vec[k]; smp();
      chk("gen_new_pc", u_if.new_pc, 32'h40);
      nxt(); u_if.excepttype_i = 0; smp();
    end

    // watchdog trips after 4 stalled edges and stays set
    nxt(); u_if.stallreq_ex = 1;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("wdt_pre", {31'd0, u_if.wdt_timeout}, 32'd0);
      nxt();
    end
    u_if.stallreq_ex = 0; smp();
    chk("wdt_set", {31'd0, u_if.wdt_timeout}, 32'd1);
    nxt(); smp();
    chk("wdt_sticky", {31'd0, u_if.wdt_timeout}, 32'd1);
    rst = 1; nxt(); rst = 0; smp();
    chk("wdt_rst", {31'd0, u_if.wdt_timeout}, 32'd0);

    // exception in the middle of a long stall clears the watchdog
    nxt(); u_if.stallreq_ex = 1;
    repeat (3) nxt();
    u_if.excepttype_i = 32'h8; nxt();
    u_if.excepttype_i = 0; nxt();
    repeat (3) nxt();
    u_if.stallreq_ex = 0; smp();
    chk("wdt_exc_clear", {31'd0, u_if.wdt_timeout}, 32'd0);

    // reset mid-stall
    nxt(); u_if.stallreq_mem = 1; nxt(); nxt(); rst = 1; smp();
    chk("rst_mid_stall", {26'd0, u_if.stall}, 32'd0);
    nxt(); rst = 0; u_if.stallreq_mem = 0; smp();
    chk("rst_mid_state", {30'd0, u_if.state_o}, 32'd0);

`ifdef PIPE_PERF_EN
    rst = 1; nxt(); rst = 0;
    u_if.stallreq_if = 1; repeat (5) nxt();
    u_if.stallreq_if = 0; u_if.excepttype_i = 32'hc; nxt();
    u_if.excepttype_i = 0; nxt();
    u_if.excepttype_i = 32'h1; nxt();
    u_if.excepttype_i = 0; nxt(); smp();
    chk("perf_stall_cycles", stall_cycles, 32'd5);
    chk("perf_flush_count", flush_count, 32'd2);
    nxt(); u_if.stallreq_id = 1; nxt(); rst = 1; nxt(); rst = 0; u_if.stallreq_id = 0; smp();
    chk("perf_rst_stall", stall_cycles, 32'd0);
    chk("perf_rst_flush", flush_count, 32'd0);
`endif

    nxt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit for the 5-stage MIPS core. It drives the stall/flush side of the protocol that the inter-stage registers (pc_reg, if_id, id_ex, ex_mem, mem_wb) consume.
- Arbitrates stall requests from IF/ID/EX/MEM and turns MEM-stage exceptions into a flush plus a redirect PC.
- Sequential parts: a post-flush FSM, a stall watchdog counter and optional performance counters.

Parameters:
- WDT_LIMIT, 255: consecutive stalled cycles that trip the watchdog (1..65535).
- CNT_W, 32: width of the performance counters (only with PIPE_PERF_EN).

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- stallreq_if  in  1  IF stall request (bus busy)
- stallreq_id  in  1  ID stall request (load-use)
- stallreq_ex  in  1  EX stall request (multi-cycle mult/div)
- stallreq_mem  in  1  MEM stall request (data bus busy)
- excepttype_i  in  32  final exception type from MEM; 0 = none
- cp0_epc_i  in  32  EPC for eret
- stall  out  6  [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb; 1 = Stop
- flush  out  1  clear all pipeline registers this cycle
- new_pc  out  32  redirect target, valid while flush=1
- wdt_timeout  out  1  sticky watchdog flag
- state_o  out  2  FSM state: 0 RUN, 1 STALL, 2 FLUSH

Behaviour:
- stall, flush and new_pc are combinational from the inputs and the state. This is required so stall[2]=1 with stall[3]=0 inserts a bubble in the same cycle.
- Reset (rst=1 at a clk edge):
  - state=RUN, wdt counter=0, wdt_timeout=0, perf counters=0.
  - While rst=1, stall=6'b000000, flush=0, new_pc=0.
  - rst mid-stall or mid-flush overrides everything.
- Priority: exception > MEM > EX > ID > IF.
  - excepttype_i!=0: flush=1, stall=6'b000000.
  - MEM request: stall=6'b011111.
  - EX request: stall=6'b001111.
  - ID request: stall=6'b000111.
  - IF request: stall=6'b000011.
  - No request: stall=6'b000000.
- new_pc decode when flush=1:
  - 32'h1 (interrupt) -> 32'h00000020.
  - 32'h8 syscall, 32'ha invalid instruction, 32'hd trap, 32'hc overflow -> 32'h00000040.
  - 32'he (eret) -> cp0_epc_i.
  - Any other nonzero -> 32'h00000040.
  - When flush=0, new_pc=0.
- FSM, evaluated at each clk edge with rst=0:
  - RUN: exception -> FLUSH; any stall bit set -> STALL; else RUN.
  - STALL: exception -> FLUSH; stall still set -> STALL; else RUN.
  - FLUSH lasts exactly one cycle:
    - All stall requests are ignored: stall=0, flush=0 (pipeline holds only bubbles).
    - excepttype_i is also ignored.
    - Next state is always RUN.
- Watchdog:
  - Counter increments on each cycle with stall!=0.
  - Clears on any cycle with stall==0 or flush=1.
  - Saturates at WDT_LIMIT.
  - When the count reaches WDT_LIMIT, wdt_timeout is set and stays set until rst. It does not force a flush.
- Simultaneous exception and stall request: the exception wins, stall=0, and the watchdog clears.

Optional Feature:
- Macro PIPE_PERF_EN adds two outputs:
  - stall_cycles_o [CNT_W-1:0]: +1 for each cycle with stall!=0.
  - flush_count_o [CNT_W-1:0]: +1 for each cycle with flush=1.
- Both counters wrap at 2^CNT_W and reset to 0.
- Without the macro, neither port nor either counter exists. All other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all requests 0 -> stall=0, flush=0, new_pc=0, state_o=0, wdt_timeout=0.
- Priority: stallreq_id=1 and stallreq_ex=1 for 3 cycles, then both 0.
  - During: stall=6'b001111, state_o=1.
  - After: stall=0, state_o=0 the following cycle.
- Exception overrides stall: stallreq_mem=1 with excepttype_i=32'hc.
  - Same cycle: flush=1, new_pc=32'h40, stall=0.
  - Next cycle: state_o=2, flush=0, stall=0 despite stallreq_mem=1.
  - Cycle after: stall=6'b011111.
- eret: excepttype_i=32'he, cp0_epc_i=32'hbfc00100 -> flush=1, new_pc=32'hbfc00100. Interrupt excepttype_i=32'h1 -> new_pc=32'h20.
- Watchdog: WDT_LIMIT=4, stallreq_ex held 4 cycles -> wdt_timeout=1 after the 4th edge, still 1 after the request drops; rst clears it. A 3-cycle stall never sets it.
- PIPE_PERF_EN: 5 stalled cycles plus 2 exceptions -> stall_cycles_o=5, flush_count_o=2. Assert rst mid-stall -> both 0.
